gb_weight_addr_seq: RTL and testbench

Parametrised read-address sequencer for the global buffer feeding the matrix-vector PE array. It supersedes the fixed 384×96, 4-PE weight read-address logic. Row count, column count, weight base address and PE lane count are configurable at run time or build time. Once per cycle it issues one weight read address and one data-vector address, tagged with the destination PE lane. It adds per-lane accumulator-clear, per-row-group completion and stall support, and sits between the global buffer read ports and the PE array.

---
 rtl/gb_weight_addr_seq.sv | 175 +++++++++++++++++
 tb/tb_gb_weight_addr_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_weight_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : gb_weight_addr_seq
//  Purpose  : Global-buffer weight/data read-address sequencer for the
//             matrix-vector PE array (row group -> column -> lane order).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module gb_weight_addr_seq #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_ADDR_WIDTH = 7,
  parameter int DIM_WIDTH       = 10,
  parameter int NUM_PE          = 4,
  parameter int LANE_WIDTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIM_WIDTH-1:0]       rows_cfg,
  input  logic [DIM_WIDTH-1:0]       cols_cfg,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic                       stall,
  output logic                       busy,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      gb_rd_weight_addr,
  output logic [DATA_ADDR_WIDTH-1:0] gb_rd_data_addr,
  output logic [LANE_WIDTH-1:0]      pe_lane,
  output logic                       acc_clear,
  output logic                       row_jumped,
  output logic                       compute_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [DIM_WIDTH-1:0]  c_dim_one  = DIM_WIDTH'(1);
  localparam logic [LANE_WIDTH-1:0] c_lane_one = LANE_WIDTH'(1);
  localparam logic [LANE_WIDTH-1:0] c_last_lane = LANE_WIDTH'(NUM_PE - 1);

  state_t                r_state;
  logic [DIM_WIDTH-1:0]  r_rows, r_cols;
  // Pointer to the issue currently on the outputs.
  logic [DIM_WIDTH-1:0]  r_row, r_col, r_grp_row;
  logic [LANE_WIDTH-1:0] r_lane;
  logic [ADDR_WIDTH-1:0] r_grp_addr, r_row_addr;

  logic [DIM_WIDTH-1:0]  w_rows, w_cols;
  logic [DIM_WIDTH-1:0]  w_n_row, w_n_col, w_n_grp_row;
  logic [LANE_WIDTH-1:0] w_n_lane;
  logic [ADDR_WIDTH-1:0] w_n_grp_addr, w_n_row_addr, w_n_addr;
  logic                  w_cur_last_lane, w_n_last_lane, w_last_issue;

  always_comb begin
    w_rows = (r_state == S_IDLE) ? rows_cfg : r_rows;
    w_cols = (r_state == S_IDLE) ? cols_cfg : r_cols;

    w_cur_last_lane = (r_lane == c_last_lane) || (r_row == r_rows - c_dim_one);
    w_last_issue    = (r_row == r_rows - c_dim_one) && (r_col == r_cols - c_dim_one);

    w_n_row      = r_row;
    w_n_col      = r_col;
    w_n_lane     = r_lane;
    w_n_grp_row  = r_grp_row;
    w_n_grp_addr = r_grp_addr;
    w_n_row_addr = r_row_addr;

    if (r_state == S_IDLE) begin
      w_n_row      = '0;
      w_n_col      = '0;
      w_n_lane     = '0;
      w_n_grp_row  = '0;
      w_n_grp_addr = base_addr;
      w_n_row_addr = base_addr;
    end else if (!w_cur_last_lane) begin
      w_n_lane     = r_lane + c_lane_one;
      w_n_row      = r_row + c_dim_one;
      w_n_row_addr = r_row_addr + ADDR_WIDTH'(r_cols);
    end else if (r_col != r_cols - c_dim_one) begin
      w_n_col      = r_col + c_dim_one;
      w_n_lane     = '0;
      w_n_row      = r_grp_row;
      w_n_row_addr = r_grp_addr;
    end else begin
      // Only a full group can be followed by another, so the last lane's row
      // start plus one row stride is exactly the next group's base.
      w_n_col      = '0;
      w_n_lane     = '0;
      w_n_row      = r_row + c_dim_one;
      w_n_grp_row  = r_row + c_dim_one;
      w_n_grp_addr = r_row_addr + ADDR_WIDTH'(r_cols);
      w_n_row_addr = r_row_addr + ADDR_WIDTH'(r_cols);
    end

    w_n_last_lane = (w_n_lane == c_last_lane) || (w_n_row == w_rows - c_dim_one);
    w_n_addr      = w_n_row_addr + ADDR_WIDTH'(w_n_col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_rows            <= '0;
      r_cols            <= '0;
      r_row             <= '0;
      r_col             <= '0;
      r_lane            <= '0;
      r_grp_row         <= '0;
      r_grp_addr        <= '0;
      r_row_addr        <= '0;
      busy              <= 1'b0;
      rd_en             <= 1'b0;
      gb_rd_weight_addr <= '0;
      gb_rd_data_addr   <= '0;
      pe_lane           <= '0;
      acc_clear         <= 1'b0;
      row_jumped        <= 1'b0;
      compute_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows <= rows_cfg;
            r_cols <= cols_cfg;
            if (rows_cfg == '0 || cols_cfg == '0) begin
              r_state      <= S_DONE;
              compute_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              busy    <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (!stall && w_last_issue) begin
            r_state           <= S_DONE;
            busy              <= 1'b0;
            rd_en             <= 1'b0;
            gb_rd_weight_addr <= '0;
            gb_rd_data_addr   <= '0;
            pe_lane           <= '0;
            acc_clear         <= 1'b0;
            row_jumped        <= 1'b0;
            compute_done      <= 1'b1;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          compute_done <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Load the next issue either on an accepted non-empty start or on an
      // unstalled advance that is not the final issue of the pass.
      if ((r_state == S_IDLE && start && rows_cfg != '0 && cols_cfg != '0) ||
          (r_state == S_ISSUE && !stall && !w_last_issue)) begin
        r_row             <= w_n_row;
        r_col             <= w_n_col;
        r_lane            <= w_n_lane;
        r_grp_row         <= w_n_grp_row;
        r_grp_addr        <= w_n_grp_addr;
        r_row_addr        <= w_n_row_addr;
        rd_en             <= 1'b1;
        gb_rd_weight_addr <= w_n_addr;
        gb_rd_data_addr   <= DATA_ADDR_WIDTH'(w_n_col);
        pe_lane           <= w_n_lane;
        acc_clear         <= (w_n_col == '0);
        row_jumped        <= (w_n_col == w_cols - c_dim_one) && w_n_last_lane;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_weight_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_weight_addr_seq
//  Purpose  : Directed self-checking bench for gb_weight_addr_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gb_weight_addr_seq;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [9:0]  rows_cfg, cols_cfg;
  logic [15:0] base_addr;
  logic        busy, rd_en, acc_clear, row_jumped, compute_done;
  logic [15:0] gb_rd_weight_addr;
  logic [6:0]  gb_rd_data_addr;
  logic [1:0]  pe_lane;

  int n_checks = 0;
  int n_fail   = 0;

  // Records of one pass, filled by run_pass.
  int q_addr[$], q_data[$], q_lane[$], q_acc[$], q_rj[$];
  int q_frz_addr[$], q_frz_lane[$], q_frz_en[$];
  int done_cycle, busy_cycles, done_busy, timed_out;

  always #5 clk = ~clk;

  gb_weight_addr_seq #(
    .ADDR_WIDTH(16), .DATA_ADDR_WIDTH(7), .DIM_WIDTH(10), .NUM_PE(4), .LANE_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rows_cfg(rows_cfg), .cols_cfg(cols_cfg),
    .base_addr(base_addr), .stall(stall), .busy(busy), .rd_en(rd_en),
    .gb_rd_weight_addr(gb_rd_weight_addr), .gb_rd_data_addr(gb_rd_data_addr),
    .pe_lane(pe_lane), .acc_clear(acc_clear), .row_jumped(row_jumped),
    .compute_done(compute_done)
  );

  // Cycle 0 is the cycle in which start is high; samples taken on negedges.
  task automatic run_pass(input int r, input int c, input int a, input int stall_addr,
                          input int stall_len, input int poke_cycle, input int limit);
    int  cycle;
    bit  stalled;
    q_addr.delete(); q_data.delete(); q_lane.delete(); q_acc.delete(); q_rj.delete();
    q_frz_addr.delete(); q_frz_lane.delete(); q_frz_en.delete();
    done_cycle = -1; busy_cycles = 0; done_busy = -1; timed_out = 0;
    stalled = 0; cycle = 0;
    @(negedge clk);
    rows_cfg = 10'(r); cols_cfg = 10'(c); base_addr = 16'(a); start = 1'b1;
    forever begin
      @(negedge clk);
      cycle++;
      start = (cycle == poke_cycle);
      if (cycle == poke_cycle) begin
        rows_cfg = 10'd1; cols_cfg = 10'd1; base_addr = 16'd5555;
      end
      if (busy) busy_cycles++;
      if (rd_en) begin
        q_addr.push_back(int'(gb_rd_weight_addr));
        q_data.push_back(int'(gb_rd_data_addr));
        q_lane.push_back(int'(pe_lane));
        q_acc.push_back(int'(acc_clear));
        q_rj.push_back(int'(row_jumped));
        if (!stalled && int'(gb_rd_weight_addr) == stall_addr) begin
          stalled = 1;
          stall = 1'b1;
          repeat (stall_len) begin
            @(negedge clk);
            cycle++;
            if (busy) busy_cycles++;
            q_frz_addr.push_back(int'(gb_rd_weight_addr));
            q_frz_lane.push_back(int'(pe_lane));
            q_frz_en.push_back(int'(rd_en));
          end
          stall = 1'b0;
        end
      end
      if (compute_done) begin
        done_cycle = cycle;
        done_busy  = int'(busy);
        break;
      end
      if (cycle > limit) begin
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    rows_cfg = '0; cols_cfg = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, rd_en, gb_rd_weight_addr, gb_rd_data_addr, pe_lane, acc_clear, row_jumped,
         compute_done} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {busy, rd_en, gb_rd_weight_addr,
               gb_rd_data_addr, pe_lane, acc_clear, row_jumped, compute_done});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, rd_en, compute_done} !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, rd_en, compute_done});
    end
  endtask

  task automatic test_basic();
    int ea[12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
    run_pass(4, 3, 0, -1, 0, -1, 100);
    n_checks++;
    if (q_addr.size() !== 12 || timed_out !== 0) begin
      n_fail++;
      $display("FAIL basic_count: got %0d timeout=%0d want 12", q_addr.size(), timed_out);
    end
    for (int i = 0; i < 12; i++) begin
      int g_a, g_d, g_l, g_c, g_j;
      g_a = (i < q_addr.size()) ? q_addr[i] : -1;
      g_d = (i < q_addr.size()) ? q_data[i] : -1;
      g_l = (i < q_addr.size()) ? q_lane[i] : -1;
      g_c = (i < q_addr.size()) ? q_acc[i]  : -1;
      g_j = (i < q_addr.size()) ? q_rj[i]   : -1;
      n_checks++;
      if (g_a !== ea[i] || g_d !== i / 4 || g_l !== i % 4 || g_c !== int'(i < 4) ||
          g_j !== int'(i == 11)) begin
        n_fail++;
        $display("FAIL basic_issue%0d: got a=%0d d=%0d l=%0d clr=%0d rj=%0d want a=%0d d=%0d l=%0d clr=%0d rj=%0d",
                 i, g_a, g_d, g_l, g_c, g_j, ea[i], i / 4, i % 4, int'(i < 4), int'(i == 11));
      end
    end
    n_checks++;
    if (done_cycle !== 13 || done_busy !== 0 || busy_cycles !== 12) begin
      n_fail++;
      $display("FAIL basic_done: got cycle=%0d busy_at_done=%0d busy_cycles=%0d want 13 0 12",
               done_cycle, done_busy, busy_cycles);
    end
  endtask

  task automatic test_partial_group();
    int ea[12] = '{100, 102, 104, 106, 101, 103, 105, 107, 108, 110, 109, 111};
    int el[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 1};
    int ed[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    run_pass(6, 2, 100, -1, 0, -1, 100);
    n_checks++;
    if (q_addr.size() !== 12 || timed_out !== 0) begin
      n_fail++;
      $display("FAIL partial_count: got %0d timeout=%0d want 12", q_addr.size(), timed_out);
    end
    for (int i = 0; i < 12; i++) begin
      int g_a, g_d, g_l, g_c, g_j, e_c, e_j;
      g_a = (i < q_addr.size()) ? q_addr[i] : -1;
      g_d = (i < q_addr.size()) ? q_data[i] : -1;
      g_l = (i < q_addr.size()) ? q_lane[i] : -1;
      g_c = (i < q_addr.size()) ? q_acc[i]  : -1;
      g_j = (i < q_addr.size()) ? q_rj[i]   : -1;
      e_c = int'(ed[i] == 0);
      e_j = int'(i == 7 || i == 11);
      n_checks++;
      if (g_a !== ea[i] || g_d !== ed[i] || g_l !== el[i] || g_c !== e_c || g_j !== e_j) begin
        n_fail++;
        $display("FAIL partial_issue%0d: got a=%0d d=%0d l=%0d clr=%0d rj=%0d want a=%0d d=%0d l=%0d clr=%0d rj=%0d",
                 i, g_a, g_d, g_l, g_c, g_j, ea[i], ed[i], el[i], e_c, e_j);
      end
    end
    n_checks++;
    if (done_cycle !== 13) begin
      n_fail++;
      $display("FAIL partial_done: got cycle %0d want 13", done_cycle);
    end
  endtask

  task automatic test_stall();
    run_pass(4, 3, 0, 9, 3, -1, 100);
    n_checks++;
    if (q_frz_addr.size() !== 3) begin
      n_fail++;
      $display("FAIL stall_frozen_len: got %0d want 3", q_frz_addr.size());
    end
    for (int i = 0; i < q_frz_addr.size(); i++) begin
      n_checks++;
      if (q_frz_addr[i] !== 9 || q_frz_lane[i] !== 3 || q_frz_en[i] !== 1) begin
        n_fail++;
        $display("FAIL stall_frozen%0d: got a=%0d l=%0d en=%0d want a=9 l=3 en=1",
                 i, q_frz_addr[i], q_frz_lane[i], q_frz_en[i]);
      end
    end
    n_checks++;
    if (q_addr.size() !== 12 || (q_addr.size() > 4 && q_addr[4] !== 1)) begin
      n_fail++;
      $display("FAIL stall_resume: got count=%0d want 12 with issue4=1", q_addr.size());
    end
    n_checks++;
    if (done_cycle !== 16) begin
      n_fail++;
      $display("FAIL stall_done: got cycle %0d want 16", done_cycle);
    end
  endtask

  task automatic test_empty();
    run_pass(0, 3, 7, -1, 0, -1, 20);
    n_checks++;
    if (q_addr.size() !== 0 || done_cycle !== 1 || busy_cycles !== 0) begin
      n_fail++;
      $display("FAIL empty_rows: got issues=%0d done=%0d busy=%0d want 0 1 0",
               q_addr.size(), done_cycle, busy_cycles);
    end
    run_pass(5, 0, 7, -1, 0, -1, 20);
    n_checks++;
    if (q_addr.size() !== 0 || done_cycle !== 1 || busy_cycles !== 0) begin
      n_fail++;
      $display("FAIL empty_cols: got issues=%0d done=%0d busy=%0d want 0 1 0",
               q_addr.size(), done_cycle, busy_cycles);
    end
  endtask

  task automatic test_rst_mid_pass();
    int seen, stray;
    int ea[12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
    seen = 0; stray = 0;
    @(negedge clk);
    rows_cfg = 10'd4; cols_cfg = 10'd3; base_addr = 16'd0; start = 1'b1;
    for (int k = 0; k < 50 && seen < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) seen++;
    end
    n_checks++;
    if (seen !== 5 || gb_rd_weight_addr !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_reach_issue5: got seen=%0d addr=%0d want 5 1", seen, gb_rd_weight_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, rd_en, gb_rd_weight_addr, gb_rd_data_addr, pe_lane, acc_clear, row_jumped,
         compute_done} !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h want 0", {busy, rd_en, gb_rd_weight_addr,
               gb_rd_data_addr, pe_lane, acc_clear, row_jumped, compute_done});
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (compute_done || rd_en || busy) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d active cycles want 0", stray);
    end
    run_pass(4, 3, 0, -1, 0, -1, 100);
    n_checks++;
    if (q_addr.size() !== 12 || done_cycle !== 13) begin
      n_fail++;
      $display("FAIL rst_restart_count: got %0d done=%0d want 12 13", q_addr.size(), done_cycle);
    end
    for (int i = 0; i < q_addr.size() && i < 12; i++) begin
      n_checks++;
      if (q_addr[i] !== ea[i]) begin
        n_fail++;
        $display("FAIL rst_restart_issue%0d: got %0d want %0d", i, q_addr[i], ea[i]);
      end
    end
  endtask

  task automatic test_full_size();
    int rj_count, bad, idx;
    run_pass(384, 96, 0, -1, 0, 100, 40000);
    rj_count = 0; bad = 0; idx = 0;
    foreach (q_rj[i]) rj_count += q_rj[i];
    for (int g = 0; g < 96; g++)
      for (int c = 0; c < 96; c++)
        for (int l = 0; l < 4; l++) begin
          if (idx >= q_addr.size() || q_addr[idx] !== g * 4 * 96 + l * 96 + c) bad++;
          idx++;
        end
    n_checks++;
    if (q_addr.size() !== 36864 || timed_out !== 0) begin
      n_fail++;
      $display("FAIL full_count: got %0d timeout=%0d want 36864", q_addr.size(), timed_out);
    end
    n_checks++;
    if (rj_count !== 96) begin
      n_fail++;
      $display("FAIL full_row_jumped: got %0d want 96", rj_count);
    end
    n_checks++;
    if (q_addr.size() == 0 || q_addr[q_addr.size() - 1] !== 36863) begin
      n_fail++;
      $display("FAIL full_last_addr: got %0d want 36863",
               (q_addr.size() == 0) ? -1 : q_addr[q_addr.size() - 1]);
    end
    n_checks++;
    if (bad !== 0 || done_cycle !== 36865) begin
      n_fail++;
      $display("FAIL full_sequence: got %0d wrong addresses done=%0d want 0 36865", bad, done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_group();
    test_stall();
    test_empty();
    test_rst_mid_pass();
    test_full_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
